// File: rtl/mem_rr_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_access_scheduler
//  Description : Round-robin scheduler sharing one memory port between NREQ
//                requesters. Grants one requester at a time, issues a
//                one-cycle start pulse and holds the grant until mem_done or
//                until a watchdog expires.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rr_access_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            mem_done,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            mem_start,
    output logic            busy,
    output logic            timeout_err
);

    // Counter wide enough to reach TIMEOUT-1 without ever wrapping.
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  w_grant_id_nxt;
    logic [IDW-1:0]  r_last_id;
    logic [IDW-1:0]  w_last_id_nxt;
    logic            r_mem_start;
    logic            w_mem_start_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_timeout_err;
    logic            w_timeout_err_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic [IDW-1:0]  w_winner;
    logic [NREQ-1:0] w_winner_onehot;
    int              w_dist;
    int              w_best;

    // Round-robin pick: the active requester closest (upward, wrapping) to
    // the one after last_id wins.
    always_comb begin
        w_winner = '0;
        w_dist   = 0;
        w_best   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                w_dist = (i + 2 * NREQ - int'(r_last_id) - 1) % NREQ;
                if (w_dist < w_best) begin
                    w_best   = w_dist;
                    w_winner = IDW'(i);
                end
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        w_winner_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_winner_onehot[i] = (w_winner == IDW'(i));
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_id_nxt    = r_grant_id;
        w_last_id_nxt     = r_last_id;
        w_mem_start_nxt   = 1'b0;
        w_busy_nxt        = r_busy;
        w_timeout_err_nxt = 1'b0;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (|req) begin
                    w_state_nxt     = S_GRANT;
                    w_grant_nxt     = w_winner_onehot;
                    w_grant_id_nxt  = w_winner;
                    w_last_id_nxt   = w_winner;
                    w_mem_start_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_cnt_nxt       = '0;
                end
            end
            S_GRANT: begin
                if (mem_done) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = '0;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                // mem_done takes precedence over a watchdog expiry on the same edge.
                if (mem_done) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = '0;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt       = S_RELEASE;
                    w_grant_nxt       = '0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; last_id resets so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_last_id     <= IDW'(NREQ - 1);
            r_mem_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_id     <= w_last_id_nxt;
            r_mem_start   <= w_mem_start_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign mem_start   = r_mem_start;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rr_access_scheduler
//  Description : Randomized scoreboard bench for mem_rr_access_scheduler.
//                The driver predicts each transaction at the request level
//                and queues it; a monitor pops and compares on every
//                mem_start.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_rr_access_scheduler;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int IDW     = $clog2(NREQ);
    localparam int NTXN    = 60;
    localparam int NEVER   = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            mem_done;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            mem_start;
    logic            busy;
    logic            timeout_err;

    mem_rr_access_scheduler #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .mem_done    (mem_done),
        .grant       (grant),
        .grant_id    (grant_id),
        .mem_start   (mem_start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int cycles;
        bit tmo;
        bit b2b;
        bit abort;
    } exp_t;

    exp_t            sb[$];
    int              n_pass     = 0;
    int              n_total    = 0;
    bit              mon_en     = 1'b0;
    bit              hung       = 1'b0;
    bit              cur_b2b    = 1'b0;
    bit              post_abort = 1'b0;
    int              model_last = NREQ - 1;
    logic [NREQ-1:0] req_cur;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Reference arbitration: scan upward from the requester after the last winner.
    function automatic int rr_pick(int last, logic [NREQ-1:0] r);
        for (int s = 1; s <= NREQ; s++) begin
            int i;
            i = (last + s) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: pops one expectation per mem_start and follows the transaction.
    initial begin
        exp_t e;
        int   cnt;
        int   low;
        bit   have;
        low  = 0;
        have = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (mem_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                    continue;
                end
                e = sb.pop_front();
                if (e.b2b && have) chk("grant_gap", low, 2);
                chk("grant_onehot", int'(grant), 1 << e.id);
                chk("grant_id", int'(grant_id), e.id);
                chk("busy_in_grant", int'(busy), 1);
                cnt = 1;
                while (cnt < TIMEOUT + 4) begin
                    @(negedge clk);
                    if (grant == '0) break;
                    chk("grant_hold", int'(grant), 1 << e.id);
                    chk("start_one_cycle", int'(mem_start), 0);
                    cnt++;
                end
                chk("grant_cycles", cnt, e.cycles);
                if (e.abort) begin
                    chk("reset_busy", int'(busy), 0);
                    chk("reset_grant_id", int'(grant_id), 0);
                    chk("reset_tmo", int'(timeout_err), 0);
                    chk("reset_start", int'(mem_start), 0);
                    low = 1;
                end else begin
                    chk("release_busy", int'(busy), 1);
                    chk("release_tmo", int'(timeout_err), int'(e.tmo));
                    chk("release_id", int'(grant_id), e.id);
                    @(negedge clk);
                    chk("idle_busy", int'(busy), 0);
                    chk("idle_tmo", int'(timeout_err), 0);
                    chk("idle_grant", int'(grant), 0);
                    low = 2;
                end
                have = 1'b1;
            end else begin
                chk("no_grant_outside_txn", int'(grant), 0);
                low++;
            end
        end
    end

    // One transaction: predict, queue, then drive mem_done/reset around it.
    task automatic run_txn(input bit abort, input bit last, input bit use_dir,
                           input int kd, input logic [NREQ-1:0] nd);
        exp_t            e;
        int              k;
        int              j;
        int              n;
        int              c;
        int              r;
        logic [NREQ-1:0] rn;
        if (req_cur == '0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            if (post_abort) req_cur = NREQ'(1 | (1 << (NREQ - 1)));
            else            req_cur = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            post_abort = 1'b0;
            req        = req_cur;
            cur_b2b    = 1'b0;
        end
        e.id       = rr_pick(model_last, req_cur);
        model_last = e.id;
        e.b2b      = cur_b2b;
        e.abort    = abort;
        if (use_dir) begin
            k = kd;
        end else begin
            r = int'($urandom_range(0, 7));
            if (r <= 4)      k = int'($urandom_range(0, TIMEOUT - 1));
            else if (r == 5) k = TIMEOUT - 1;
            else if (r == 6) k = TIMEOUT;
            else             k = NEVER;
        end
        j = 0;
        if (abort) begin
            j          = int'($urandom_range(1, TIMEOUT - 2));
            k          = NEVER;
            e.cycles   = j + 1;
            e.tmo      = 1'b0;
            model_last = NREQ - 1;
        end else if (k < TIMEOUT) begin
            e.cycles = k + 1;
            e.tmo    = 1'b0;
        end else begin
            e.cycles = TIMEOUT;
            e.tmo    = 1'b1;
        end
        sb.push_back(e);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_start && n < 30);
        if (!mem_start) begin
            chk("start_timeout", int'(mem_start), 1);
            hung = 1'b1;
            return;
        end

        // Next request pattern goes on the bus during the grant; it may drop
        // the current requester entirely.
        if (abort || last) rn = '0;
        else if (use_dir)  rn = nd;
        else if ($urandom_range(0, 3) == 0) rn = '0;
        else rn = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        req     = rn;
        req_cur = rn;
        cur_b2b = (rn != '0);

        c = 0;
        forever begin
            mem_done = (c == k);
            reset    = abort && (c == j);
            @(negedge clk);
            mem_done = 1'b0;
            reset    = 1'b0;
            c++;
            if (grant == '0 || c > TIMEOUT + 4) break;
        end
        // A late mem_done landing in RELEASE must be ignored.
        mem_done = !abort && (k == TIMEOUT);
        @(negedge clk);
        mem_done   = 1'b0;
        post_abort = abort;
    endtask

    logic [NREQ-1:0] dir_next [8];
    int              dir_k    [8];

    initial begin
        dir_next = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 4'b0101, 4'b0101, 4'b0011};
        dir_k    = '{3, 2, TIMEOUT - 1, 2, 2, NEVER, 2, 4};

        reset    = 1'b1;
        req      = '1;
        mem_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_start", int'(mem_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tmo", int'(timeout_err), 0);
        reset    = 1'b0;
        mem_done = 1'b0;
        req      = '0;
        @(negedge clk);
        chk("idle_after_rst", int'(grant), 0);
        req_cur = 4'b0001;
        req     = req_cur;
        mon_en  = 1'b1;

        for (int t = 0; t < NTXN; t++) begin
            run_txn(t == 20 || t == 40, t == NTXN - 1, t < 8,
                    dir_k[t % 8], dir_next[t % 8]);
            if (hung) break;
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
